// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader
//   Debug readout engine on one read port of register_file. A start pulse
//   walks addresses FIRST..LAST in ascending order. Each word is presented on
//   a valid/ready stream, tagged with its address. The core's write port keeps
//   running during a dump.
//
// Ports
//   clk        rising-edge clock
//   rstn       asynchronous active-low reset
//   start      begin a dump; only looked at in IDLE
//   abort      synchronous cancel of a dump in progress
//   RA         read address to the register_file read port
//   RD         combinational read data, RD = reg[RA] in the same cycle
//   out_valid  out_addr/out_data hold a word
//   out_ready  consumer accepts the word
//   out_addr   address of the current word
//   out_data   register value of the current word
//   busy       dump in progress (READ or HOLD)
//   done       one-cycle pulse after the last word is accepted
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start, addr parked at FIRST
// READ  | RA=addr; RD is captured into out_data at the next edge
// HOLD  | word presented, waiting for out_ready
// DONE  | last word accepted; done pulses for one cycle
module regfile_dump_reader #(
    parameter int DATA  = 32,
    parameter int ADDR  = 5,
    parameter int FIRST = 0,
    parameter int LAST  = 2**ADDR-1
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            start,
    input  logic            abort,
    output logic [ADDR-1:0] RA,
    input  logic [DATA-1:0] RD,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [ADDR-1:0] out_addr,
    output logic [DATA-1:0] out_data,
    output logic            busy,
    output logic            done
);

    localparam logic [ADDR-1:0] FIRST_A = ADDR'(FIRST);
    localparam logic [ADDR-1:0] LAST_A  = ADDR'(LAST);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [ADDR-1:0] addr;
    logic [ADDR-1:0] addr_next;
    logic            valid_next;
    logic            capture;

    assign RA = addr;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            addr      <= FIRST_A;
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_data  <= '0;
        end else begin
            state     <= state_next;
            addr      <= addr_next;
            out_valid <= valid_next;
            // Capture at the same edge a register write may land: RD is still
            // the pre-write value, so a colliding write is not reflected.
            if (capture) begin
                out_addr <= addr;
                out_data <= RD;
            end
        end
    end

    always_comb begin
        state_next = state;
        addr_next  = addr;
        valid_next = out_valid;
        capture    = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;

        case (state)
            IDLE: begin
                valid_next = 1'b0;
                if (start) begin
                    addr_next  = FIRST_A;
                    state_next = READ;
                end
            end

            READ: begin
                busy = 1'b1;
                if (abort) begin
                    valid_next = 1'b0;
                    addr_next  = FIRST_A;
                    state_next = IDLE;
                end else begin
                    capture    = 1'b1;
                    valid_next = 1'b1;
                    state_next = HOLD;
                end
            end

            HOLD: begin
                busy = 1'b1;
                // abort wins over a handshake at the same edge
                if (abort) begin
                    valid_next = 1'b0;
                    addr_next  = FIRST_A;
                    state_next = IDLE;
                end else if (out_ready) begin
                    valid_next = 1'b0;
                    // compare before increment so LAST = 2**ADDR-1 never wraps
                    if (addr == LAST_A) begin
                        state_next = DONE;
                    end else begin
                        addr_next  = addr + 1'b1;
                        state_next = READ;
                    end
                end
            end

            DONE: begin
                done       = 1'b1;
                valid_next = 1'b0;
                addr_next  = FIRST_A;
                state_next = IDLE;
            end

            default: begin
                valid_next = 1'b0;
                addr_next  = FIRST_A;
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: doc/regfile_dump_reader.md
Name: regfile_dump_reader

Overview:
Debug readout engine that sits on one read port of register_file and walks it.
- On a start pulse it reads addresses FIRST..LAST in ascending order.
- Each word goes out on a valid/ready stream, tagged with its address.
- Used by the bench and by the debug path to snapshot architectural state without stopping the core's write port.

Parameters:
DATA, 32, width of a register word
ADDR, 5, width of a register address
FIRST, 0, first address dumped
LAST, 2**ADDR-1, last address dumped (FIRST <= LAST required)

Ports:
clk  input  1  rising-edge clock
rstn  input  1  asynchronous active-low reset
start  input  1  begin a dump; sampled only in IDLE
abort  input  1  synchronous cancel of a dump in progress
RA  output  ADDR  read address to register_file read port
RD  input  DATA  combinational read data from register_file (RD = reg[RA] in same cycle)
out_valid  output  1  out_addr/out_data hold a word
out_ready  input  1  consumer accepts the word
out_addr  output  ADDR  address of the current word
out_data  output  DATA  register value of the current word
busy  output  1  dump in progress (READ or HOLD)
done  output  1  one-cycle pulse after the last word is accepted

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rstn. While rstn=0:
  - state=IDLE, addr reg=FIRST, RA=FIRST.
  - out_valid=0, out_addr=0, out_data=0, busy=0, done=0.
- RA is always driven by the internal addr register.
- FSM states: IDLE, READ, HOLD, DONE.
- IDLE:
  - busy=0, out_valid=0.
  - start=1 at an edge -> addr=FIRST, go to READ.
- READ (one cycle):
  - busy=1, out_valid=0.
  - At the next edge: out_data<=RD, out_addr<=addr, out_valid<=1, go to HOLD.
- HOLD:
  - busy=1, out_valid=1; out_addr/out_data stay frozen while out_ready=0.
  - Handshake = out_valid & out_ready at an edge.
  - On handshake with addr==LAST -> out_valid<=0, go to DONE.
  - On handshake with addr!=LAST -> addr<=addr+1, out_valid<=0, go to READ.
- DONE (one cycle):
  - done=1, busy=0, addr<=FIRST, then IDLE.
- Timing:
  - start accepted at edge k -> out_valid first high after edge k+1.
  - Steady throughput is 1 word per 2 cycles.
  - With out_ready tied high, the last handshake is at edge k+2*(LAST-FIRST+1); done is high in the following cycle.
- start outside IDLE is ignored; a dump is never restarted mid-way.
- abort=1 in READ or HOLD:
  - Takes priority over a handshake at the same edge.
  - At that edge: out_valid<=0, addr<=FIRST, go to IDLE.
  - done is not pulsed; out_data/out_addr retain their last values.
- abort in IDLE or DONE has no effect.
- Write collision: the register file writes at the same edge the reader captures. If WE=1 with WA==RA at that edge, out_data is the pre-write (old) value. A write to an address after its capture edge is not reflected.
- Address increment never wraps: the dump terminates at LAST. LAST=2**ADDR-1 must not overflow addr. Compare before increment.
- Reset asserted mid-dump clears everything immediately (asynchronous). No done pulse.

Test Plan:
- Full dump: preload reg[i]=3*i via WE, pulse start, out_ready=1 -> expected response:
  - 32 beats with out_addr 0..31, out_data 0,3,...,93.
  - out_valid alternates 1/0.
  - done=1 exactly once, 65 cycles after the start edge; busy=0 afterwards.
- Backpressure: same preload, out_ready=0 for 5 cycles while out_addr=4 -> expected response:
  - out_valid=1, out_addr=4, out_data=12 and RA=4 held steady all 5 cycles.
  - Resumes with out_addr=5 after release.
- Start while busy: pulse start again at beat 7 -> no restart, beats continue with 8, single done.
- Abort: assert abort in the same cycle as a handshake at out_addr=10 -> expected response:
  - Beat 10 is not completed; out_valid=0 and busy=0 the next cycle.
  - done never asserted.
  - A new start then dumps from 0.
- Write collision: at the capture edge for addr 6, WE=1, WA=6, WD=77 with reg[6]=18 -> expected response:
  - out_data=18.
  - A second dump shows out_data=77 at out_addr=6.
- Reset mid-dump: drop rstn at beat 15 for 2 cycles -> expected response:
  - All outputs 0, RA=0 asynchronously.
  - After release the block sits in IDLE until the next start.
